// File: rtl/bram_stream_loader.sv
// rtl/bram_stream_loader.sv - packs a valid/ready byte stream into WIDTH-bit words written through the BRAM wrapper
//
// Purpose: one job writes count_in words to consecutive wrapper addresses starting at start_addr_in.
//   Bytes are shifted in MSB-first, so the first byte of a word lands in the top byte. Each full word is
//   written with a single-cycle wr_enable_out and the loader waits for the wrapper's finished flag.
// Ports:
//   clk_in, rst_in (async, active-low)
//   start_in, start_addr_in, count_in                     job control (sampled only in IDLE)
//   byte_in, byte_valid_in, byte_ready_out                 input byte stream
//   wr_addr_out, wr_data_out, wr_enable_out, wr_finished_in wrapper write interface
//   busy_out, done_out, words_written_out                  job status
//   checksum_out                                           present only with LOADER_CHECKSUM_EN defined
// Configuration: LOADER_CHECKSUM_EN adds checksum_out (mod-256 sum of bytes accepted since the last start).
module bram_stream_loader #(
  parameter  int ADDRS      = 1024,
  parameter  int BRAM_WIDTH = 64,
  parameter  int PIECES     = 32,
  localparam int ADDR_SIZE  = $clog2(ADDRS),
  localparam int WIDTH      = PIECES * BRAM_WIDTH,
  localparam int BYTES      = WIDTH / 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [ADDR_SIZE-1:0] start_addr_in,
  input  logic [ADDR_SIZE:0]   count_in,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid_in,
  output logic                 byte_ready_out,
  output logic [ADDR_SIZE-1:0] wr_addr_out,
  output logic [WIDTH-1:0]     wr_data_out,
  output logic                 wr_enable_out,
  input  logic                 wr_finished_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [ADDR_SIZE:0]   words_written_out
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]           checksum_out
`endif
);

  localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ADDRS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ISSUE   = 3'd2,
    S_ARM     = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [BCW-1:0]       byte_cnt;
  logic [WIDTH-1:0]     word;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE:0]   count_reg;
  logic [ADDR_SIZE:0]   words_written;
  logic [ADDR_SIZE:0]   words_inc;
  logic                 start_accept;
  logic                 byte_xfer;
  logic                 last_byte;
  logic                 last_word;
  logic                 word_commit;

  assign start_accept = (state == S_IDLE) && start_in;
  assign byte_xfer    = (state == S_COLLECT) && byte_valid_in;
  assign last_byte    = (byte_cnt == LAST_BYTE);
  assign words_inc    = words_written + 1'b1;
  assign last_word    = (words_inc == count_reg);
  // The wrapper has finished the previous write: the word is committed.
  assign word_commit  = (state == S_WAIT) && wr_finished_in;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_in) begin
          state_next = (count_in == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_valid_in && last_byte) begin
          state_next = S_ISSUE;
        end
      end
      // Write is only issued while the wrapper reports idle.
      S_ISSUE: begin
        if (wr_finished_in) begin
          state_next = S_ARM;
        end
      end
      // finished_in still shows the pre-write value this cycle; skip it.
      S_ARM: state_next = S_WAIT;
      S_WAIT: begin
        if (wr_finished_in) begin
          state_next = last_word ? S_DONE : S_COLLECT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    byte_ready_out = (state == S_COLLECT);
    wr_enable_out  = (state == S_ISSUE) && wr_finished_in;
    busy_out       = (state != S_IDLE);
    done_out       = (state == S_DONE);
  end

  // Datapath: address only moves on start or on commit, both while the wrapper is idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      byte_cnt      <= '0;
      word          <= '0;
      addr          <= '0;
      count_reg     <= '0;
      words_written <= '0;
    end else begin
      if (start_accept) begin
        addr          <= start_addr_in;
        count_reg     <= count_in;
        words_written <= '0;
        byte_cnt      <= '0;
      end
      if (byte_xfer) begin
        word     <= {word[WIDTH-9:0], byte_in};
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end
      if (word_commit) begin
        words_written <= words_inc;
        if (!last_word) begin
          addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        end
      end
    end
  end

  assign wr_addr_out       = addr;
  assign wr_data_out       = word;
  assign words_written_out = words_written;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      checksum <= '0;
    end else if (start_accept) begin
      checksum <= '0;
    end else if (byte_xfer) begin
      checksum <= checksum + byte_in;
    end
  end

  assign checksum_out = checksum;
`endif

endmodule
